// File: rtl/id_stage_if.sv
// Bundle between the IF/ID register, the ID stage and its consumers.
// Slave is the decode stage; master is whatever feeds and observes it.
interface id_stage_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] pc_in;
    logic [31:0]      instruction;
    logic [3:0]       status;
    logic             hazard;
    logic             flush;
    logic             freeze;
    logic             wb_en_in;
    logic [3:0]       wb_dest;
    logic [WIDTH-1:0] wb_value;

    logic [3:0]       src1;
    logic [3:0]       src2;
    logic             two_src;

    logic [WIDTH-1:0] pc_out;
    logic [WIDTH-1:0] val_rn;
    logic [WIDTH-1:0] val_rm;
    logic             wb_en;
    logic             mem_r_en;
    logic             mem_w_en;
    logic             b;
    logic             s;
    logic             imm;
    logic [3:0]       exe_cmd;
    logic [11:0]      shift_operand;
    logic [23:0]      signed_imm_24;
    logic [3:0]       dest;

    modport slave (
        input  pc_in, instruction, status, hazard, flush, freeze,
        input  wb_en_in, wb_dest, wb_value,
        output src1, src2, two_src,
        output pc_out, val_rn, val_rm, wb_en, mem_r_en, mem_w_en,
        output b, s, imm, exe_cmd, shift_operand, signed_imm_24, dest
    );

    modport master (
        output pc_in, instruction, status, hazard, flush, freeze,
        output wb_en_in, wb_dest, wb_value,
        input  src1, src2, two_src,
        input  pc_out, val_rn, val_rm, wb_en, mem_r_en, mem_w_en,
        input  b, s, imm, exe_cmd, shift_operand, signed_imm_24, dest
    );
endinterface

// File: rtl/id_stage.sv
// ARM-style decode stage: register file, control decode, condition
// check and the ID/EX pipeline register with flush/freeze.
module id_stage #(
    parameter int REG_COUNT = 15,
    parameter int WIDTH     = 32
) (
    input  logic       clk,
    input  logic       rst,
    id_stage_if.slave  bus
);
    localparam logic [3:0] PC_IDX = 4'(REG_COUNT);

    logic [WIDTH-1:0] r_regs [0:REG_COUNT-1];

    logic [1:0]  w_mode;
    logic        w_i;
    logic [3:0]  w_opcode;
    logic        w_s_bit;
    logic [3:0]  w_rn;
    logic [3:0]  w_rd;
    logic [3:0]  w_rm;
    logic [3:0]  w_cond;
    logic        w_str;
    logic [3:0]  w_src2;
    logic [WIDTH-1:0] w_val_rn;
    logic [WIDTH-1:0] w_val_rm;

    logic        w_n, w_z, w_c, w_v;
    logic        w_cond_ok;
    logic        w_bubble;

    logic        w_wb_en;
    logic        w_mem_r;
    logic        w_mem_w;
    logic        w_b;
    logic        w_s;
    logic        w_imm;
    logic [3:0]  w_cmd;

    assign w_cond   = bus.instruction[31:28];
    assign w_mode   = bus.instruction[27:26];
    assign w_i      = bus.instruction[25];
    assign w_opcode = bus.instruction[24:21];
    assign w_s_bit  = bus.instruction[20];
    assign w_rn     = bus.instruction[19:16];
    assign w_rd     = bus.instruction[15:12];
    assign w_rm     = bus.instruction[3:0];

    // Bit 20 doubles as the L bit for memory instructions.
    assign w_str  = (w_mode == 2'b01) && !w_s_bit;
    assign w_src2 = w_str ? w_rd : w_rm;

    assign bus.src1    = w_rn;
    assign bus.src2    = w_src2;
    assign bus.two_src = w_str || ((w_mode == 2'b00) && !w_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < REG_COUNT; k++) begin
                r_regs[k] <= '0;
            end
        end else if (bus.wb_en_in && bus.wb_dest < PC_IDX) begin
            r_regs[bus.wb_dest] <= bus.wb_value;
        end
    end

    // Index 15 is the pc; a pending writeback bypasses the array.
    always_comb begin
        w_val_rn = '0;
        if (w_rn == PC_IDX) begin
            w_val_rn = bus.pc_in;
        end else if (bus.wb_en_in && bus.wb_dest == w_rn) begin
            w_val_rn = bus.wb_value;
        end else begin
            w_val_rn = r_regs[w_rn];
        end
    end

    always_comb begin
        w_val_rm = '0;
        if (w_src2 == PC_IDX) begin
            w_val_rm = bus.pc_in;
        end else if (bus.wb_en_in && bus.wb_dest == w_src2) begin
            w_val_rm = bus.wb_value;
        end else begin
            w_val_rm = r_regs[w_src2];
        end
    end

    assign {w_n, w_z, w_c, w_v} = bus.status;

    always_comb begin
        w_cond_ok = 1'b0;
        unique case (w_cond)
            4'b0000: w_cond_ok = w_z;
            4'b0001: w_cond_ok = !w_z;
            4'b0010: w_cond_ok = w_c;
            4'b0011: w_cond_ok = !w_c;
            4'b0100: w_cond_ok = w_n;
            4'b0101: w_cond_ok = !w_n;
            4'b0110: w_cond_ok = w_v;
            4'b0111: w_cond_ok = !w_v;
            4'b1000: w_cond_ok = w_c && !w_z;
            4'b1001: w_cond_ok = !w_c || w_z;
            4'b1010: w_cond_ok = (w_n == w_v);
            4'b1011: w_cond_ok = (w_n != w_v);
            4'b1100: w_cond_ok = !w_z && (w_n == w_v);
            4'b1101: w_cond_ok = w_z || (w_n != w_v);
            4'b1110: w_cond_ok = 1'b1;
            4'b1111: w_cond_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_wb_en = 1'b0;
        w_mem_r = 1'b0;
        w_mem_w = 1'b0;
        w_b     = 1'b0;
        w_s     = 1'b0;
        w_imm   = 1'b0;
        w_cmd   = 4'b0000;
        unique case (w_mode)
            2'b00: begin
                w_s     = w_s_bit;
                w_imm   = w_i;
                w_wb_en = 1'b1;
                unique case (w_opcode)
                    4'b1101: w_cmd = 4'b0001;
                    4'b1111: w_cmd = 4'b1001;
                    4'b0100: w_cmd = 4'b0010;
                    4'b0101: w_cmd = 4'b0011;
                    4'b0010: w_cmd = 4'b0100;
                    4'b0110: w_cmd = 4'b0101;
                    4'b0000: w_cmd = 4'b0110;
                    4'b1100: w_cmd = 4'b0111;
                    4'b0001: w_cmd = 4'b1000;
                    4'b1010: begin
                        w_cmd   = 4'b0100;
                        w_wb_en = 1'b0;
                    end
                    4'b1000: begin
                        w_cmd   = 4'b0110;
                        w_wb_en = 1'b0;
                    end
                    default: begin
                        w_cmd   = 4'b0000;
                        w_wb_en = 1'b0;
                    end
                endcase
            end
            2'b01: begin
                w_cmd   = 4'b0010;
                w_imm   = 1'b1;
                w_mem_r = w_s_bit;
                w_wb_en = w_s_bit;
                w_mem_w = !w_s_bit;
            end
            2'b10: w_b = 1'b1;
            2'b11: ;
        endcase
    end

    assign w_bubble = !w_cond_ok || bus.hazard;

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            bus.pc_out        <= '0;
            bus.val_rn        <= '0;
            bus.val_rm        <= '0;
            bus.wb_en         <= 1'b0;
            bus.mem_r_en      <= 1'b0;
            bus.mem_w_en      <= 1'b0;
            bus.b             <= 1'b0;
            bus.s             <= 1'b0;
            bus.imm           <= 1'b0;
            bus.exe_cmd       <= 4'b0000;
            bus.shift_operand <= '0;
            bus.signed_imm_24 <= '0;
            bus.dest          <= 4'b0000;
        end else if (!bus.freeze) begin
            bus.pc_out        <= bus.pc_in;
            bus.val_rn        <= w_val_rn;
            bus.val_rm        <= w_val_rm;
            bus.wb_en         <= w_wb_en && !w_bubble;
            bus.mem_r_en      <= w_mem_r && !w_bubble;
            bus.mem_w_en      <= w_mem_w && !w_bubble;
            bus.b             <= w_b && !w_bubble;
            bus.s             <= w_s && !w_bubble;
            bus.imm           <= w_imm;
            bus.exe_cmd       <= w_bubble ? 4'b0000 : w_cmd;
            bus.shift_operand <= bus.instruction[11:0];
            bus.signed_imm_24 <= bus.instruction[23:0];
            bus.dest          <= w_rd;
        end
    end
endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: hand-computed vectors, checked after
// each rising edge and on the combinational source outputs.
module tb_id_stage;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    id_stage_if bus ();

    id_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
        bus.instruction = instr;
        bus.pc_in       = pc;
    endtask

    initial begin
        rst             = 1'b1;
        bus.pc_in       = 32'h0;
        bus.instruction = 32'h0;
        bus.status      = 4'b0000;
        bus.hazard      = 1'b0;
        bus.flush       = 1'b0;
        bus.freeze      = 1'b0;
        bus.wb_en_in    = 1'b0;
        bus.wb_dest     = 4'h0;
        bus.wb_value    = 32'h0;

        step();
        step();
        chk("rst_pc_out", bus.pc_out, 32'h0);
        chk("rst_exe_cmd", {28'h0, bus.exe_cmd}, 32'h0);
        chk("rst_wb_en", {31'h0, bus.wb_en}, 32'h0);
        chk("rst_val_rn", bus.val_rn, 32'h0);

        drive(32'hE1A02000, 32'h100);
        rst = 1'b0;
        step();
        chk("mov_reg_val_rm", bus.val_rm, 32'h0);
        chk("mov_reg_dest", {28'h0, bus.dest}, 32'h2);
        chk("mov_reg_pc_out", bus.pc_out, 32'h100);

        drive(32'hE3A00014, 32'h104);
        #1;
        chk("movi_two_src", {31'h0, bus.two_src}, 32'h0);
        step();
        chk("movi_exe_cmd", {28'h0, bus.exe_cmd}, 32'h1);
        chk("movi_wb_en", {31'h0, bus.wb_en}, 32'h1);
        chk("movi_imm", {31'h0, bus.imm}, 32'h1);
        chk("movi_dest", {28'h0, bus.dest}, 32'h0);
        chk("movi_shift", {20'h0, bus.shift_operand}, 32'h014);

        drive(32'hE0802001, 32'h108);
        bus.wb_en_in = 1'b1;
        bus.wb_dest  = 4'h0;
        bus.wb_value = 32'h5;
        #1;
        chk("add_src2", {28'h0, bus.src2}, 32'h1);
        chk("add_two_src", {31'h0, bus.two_src}, 32'h1);
        step();
        chk("add_bypass_val_rn", bus.val_rn, 32'h5);
        chk("add_exe_cmd", {28'h0, bus.exe_cmd}, 32'h2);
        chk("add_dest", {28'h0, bus.dest}, 32'h2);

        bus.wb_en_in = 1'b0;
        drive(32'hE1A02000, 32'h10C);
        step();
        chk("r0_written", bus.val_rm, 32'h5);

        drive(32'h03A00014, 32'h110);
        bus.status = 4'b0000;
        step();
        chk("moveq_fail_wb_en", {31'h0, bus.wb_en}, 32'h0);
        chk("moveq_fail_exe", {28'h0, bus.exe_cmd}, 32'h0);
        chk("moveq_fail_dest", {28'h0, bus.dest}, 32'h0);
        chk("moveq_fail_imm", {31'h0, bus.imm}, 32'h1);

        bus.status = 4'b0100;
        step();
        chk("moveq_pass_wb_en", {31'h0, bus.wb_en}, 32'h1);
        chk("moveq_pass_exe", {28'h0, bus.exe_cmd}, 32'h1);

        drive(32'hF3A00014, 32'h114);
        step();
        chk("cond_nv_wb_en", {31'h0, bus.wb_en}, 32'h0);

        drive(32'hE3A00014, 32'h118);
        bus.status = 4'b0000;
        bus.hazard = 1'b1;
        #1;
        chk("haz_src1", {28'h0, bus.src1}, 32'h0);
        step();
        chk("haz_wb_en", {31'h0, bus.wb_en}, 32'h0);
        chk("haz_exe", {28'h0, bus.exe_cmd}, 32'h0);
        chk("haz_shift", {20'h0, bus.shift_operand}, 32'h014);
        bus.hazard = 1'b0;

        drive(32'hE5901000, 32'h11C);
        step();
        chk("ldr_mem_r", {31'h0, bus.mem_r_en}, 32'h1);
        chk("ldr_wb_en", {31'h0, bus.wb_en}, 32'h1);
        chk("ldr_exe", {28'h0, bus.exe_cmd}, 32'h2);

        drive(32'hE5801000, 32'h120);
        bus.wb_en_in = 1'b1;
        bus.wb_dest  = 4'h1;
        bus.wb_value = 32'h77;
        #1;
        chk("str_src2", {28'h0, bus.src2}, 32'h1);
        chk("str_two_src", {31'h0, bus.two_src}, 32'h1);
        step();
        chk("str_mem_w", {31'h0, bus.mem_w_en}, 32'h1);
        chk("str_wb_en", {31'h0, bus.wb_en}, 32'h0);
        chk("str_val_rm", bus.val_rm, 32'h77);
        bus.wb_en_in = 1'b0;

        drive(32'hEA000003, 32'h124);
        step();
        chk("br_b", {31'h0, bus.b}, 32'h1);
        chk("br_imm24", {8'h0, bus.signed_imm_24}, 32'h3);
        chk("br_wb_en", {31'h0, bus.wb_en}, 32'h0);

        drive(32'hE1500001, 32'h128);
        step();
        chk("cmp_s", {31'h0, bus.s}, 32'h1);
        chk("cmp_wb_en", {31'h0, bus.wb_en}, 32'h0);
        chk("cmp_exe", {28'h0, bus.exe_cmd}, 32'h4);

        drive(32'hE3A00014, 32'h12C);
        bus.freeze = 1'b1;
        step();
        chk("frz_exe", {28'h0, bus.exe_cmd}, 32'h4);
        chk("frz_pc_out", bus.pc_out, 32'h128);
        chk("frz_val_rm", bus.val_rm, 32'h77);

        bus.flush = 1'b1;
        step();
        chk("flush_exe", {28'h0, bus.exe_cmd}, 32'h0);
        chk("flush_pc_out", bus.pc_out, 32'h0);
        chk("flush_val_rm", bus.val_rm, 32'h0);
        chk("flush_imm", {31'h0, bus.imm}, 32'h0);
        bus.flush  = 1'b0;
        bus.freeze = 1'b0;

        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(32'hE1A02000, 32'h130);
        step();
        chk("rst_clears_r0", bus.val_rm, 32'h0);
        chk("post_rst_pc_out", bus.pc_out, 32'h130);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
